arbiter_multiplexer: RTL and testbench

Registered N-channel stream multiplexer with valid/ready handshakes and round-robin arbitration. It merges several producer streams (e.g. instruction-fetch and data-memory requests into a shared bus port) onto one output stream and records which channel each beat came from. It generalises the combinational select-based multiplexer: the select is computed internally, and the output is held in a one-entry pipeline register with full throughput.

---
 rtl/multiplexer_pkg.sv | 29 ++
 rtl/arbiter_multiplexer_rr_arbiter.sv | 45 ++++
 rtl/arbiter_multiplexer.sv | 84 ++++++++
 tb/tb_arbiter_multiplexer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/multiplexer_pkg.sv
// multiplexer_pkg
//   Helpers shared by every stream multiplexer in the codebase.
//   channel_slice : extracts channel c from a packed bus where channel 0
//                   occupies the most significant slice.
//   SEL_WIDTH     : width of a channel index for a given channel count.
//   Bus and width limits bound the generic slice helper; callers zero-extend
//   their bus to MAX_BUS bits and truncate the result to their own width.
package multiplexer_pkg;

    localparam int unsigned MAX_WIDTH    = 256;
    localparam int unsigned MAX_CHANNELS = 16;
    localparam int unsigned MAX_BUS      = MAX_WIDTH * MAX_CHANNELS;

    typedef int unsigned uint_t;

    function automatic int unsigned SEL_WIDTH(input int unsigned channels);
        return (channels < 2) ? 1 : uint_t'($clog2(channels));
    endfunction

    function automatic logic [MAX_WIDTH-1:0] channel_slice(
        input logic [MAX_BUS-1:0] bus,
        input int unsigned        c,
        input int unsigned        channels,
        input int unsigned        width
    );
        return MAX_WIDTH'(bus >> ((channels - 1 - c) * width));
    endfunction

endpackage

// File: rtl/arbiter_multiplexer_rr_arbiter.sv
// rr_arbiter
//   Stateless rotating-priority arbiter. The first requesting channel found
//   in the order ptr, ptr+1, ... (wrapping modulo CHANNELS) wins.
//   Ports:
//     request     [CHANNELS]  channel requests
//     ptr         [SEL]       highest-priority channel this cycle
//     grant       [CHANNELS]  one-hot grant, zero when nothing requests
//     grant_index [SEL]       index of the granted channel (0 when none)
module rr_arbiter
    import multiplexer_pkg::*;
#(
    parameter int unsigned CHANNELS = 2
) (
    input  logic [CHANNELS-1:0]            request,
    input  logic [SEL_WIDTH(CHANNELS)-1:0] ptr,
    output logic [CHANNELS-1:0]            grant,
    output logic [SEL_WIDTH(CHANNELS)-1:0] grant_index
);

    localparam int unsigned SW = SEL_WIDTH(CHANNELS);

    // One extra bit so ptr + k cannot overflow before the explicit wrap;
    // subtracting CHANNELS keeps non-power-of-two counts correct.
    logic [SW:0] candidate;
    logic        found;

    always_comb begin
        grant       = '0;
        grant_index = '0;
        found       = 1'b0;
        candidate   = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            candidate = {1'b0, ptr} + (SW+1)'(k);
            if (candidate >= (SW+1)'(CHANNELS)) begin
                candidate = candidate - (SW+1)'(CHANNELS);
            end
            if (!found && request[candidate[SW-1:0]]) begin
                found                      = 1'b1;
                grant[candidate[SW-1:0]]   = 1'b1;
                grant_index                = candidate[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/arbiter_multiplexer.sv
// arbiter_multiplexer
//   Registered N-channel stream multiplexer with valid/ready handshakes.
//   One output register gives full 1 beat/cycle throughput; out_sel records
//   the source channel of each beat.
//   Configuration macro ARBITER_ROUND_ROBIN_EN:
//     defined   : round-robin, priority pointer advances past each winner
//     undefined : fixed priority, lowest-numbered requesting channel wins
//   Ports:
//     clock, reset   rising-edge clock, asynchronous active-high reset
//     in_bus         packed channel data, channel 0 in the MSBs
//     in_valid       per-channel beat offered
//     in_ready       per-channel beat accepted (one-hot or zero)
//     out_data       registered selected beat
//     out_sel        registered source channel of out_data
//     out_valid      output register holds a beat
//     out_ready      consumer accepts the output beat
module arbiter_multiplexer
    import multiplexer_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*WIDTH-1:0]      in_bus,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [SEL_WIDTH(CHANNELS)-1:0] out_sel,
    output logic                           out_valid,
    input  logic                           out_ready
);

    localparam int unsigned SW = SEL_WIDTH(CHANNELS);

    logic [CHANNELS-1:0] grant;
    logic [SW-1:0]       grant_index;
    logic [SW-1:0]       ptr;
    logic                load;
    logic                take;

    rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_arbiter (
        .request     (in_valid),
        .ptr         (ptr),
        .grant       (grant),
        .grant_index (grant_index)
    );

    assign load     = !out_valid || out_ready;
    // grant only ever selects a requesting channel, so any in_ready bit
    // implies a completed input handshake.
    assign in_ready = load ? grant : '0;
    assign take     = |in_ready;

`ifdef ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= (grant_index == SW'(CHANNELS - 1)) ? '0 : grant_index + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= WIDTH'(channel_slice(MAX_BUS'(in_bus), uint_t'(grant_index),
                                              CHANNELS, WIDTH));
            out_sel   <= grant_index;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arbiter_multiplexer.sv
module tb_arbiter_multiplexer;

    localparam int unsigned W = 32;

`ifdef ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [W-1:0] D0 = 32'hA0A0_0000;
    localparam logic [W-1:0] D1 = 32'hB1B1_1111;
    localparam logic [W-1:0] D2 = 32'hC2C2_2222;
    localparam logic [W-1:0] D3 = 32'hD3D3_3333;
    localparam logic [W-1:0] E0 = 32'h0000_00E0;
    localparam logic [W-1:0] E1 = 32'h0000_00E1;
    localparam logic [W-1:0] E2 = 32'h0000_00E2;

    logic           clock = 1'b0;
    logic           reset;
    logic [4*W-1:0] in_bus;
    logic [3:0]     in_valid;
    logic [3:0]     in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_sel;
    logic           out_valid;
    logic           out_ready;

    logic [3*W-1:0] in_bus3;
    logic [2:0]     in_valid3;
    logic [2:0]     in_ready3;
    logic [W-1:0]   out_data3;
    logic [1:0]     out_sel3;
    logic           out_valid3;
    logic           out_ready3;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   sel;
    } beat_t;
    beat_t exp_q[$];

    logic [W-1:0] dch  [4] = '{D0, D1, D2, D3};
    logic [W-1:0] ech  [3] = '{E0, E1, E2};
    logic [1:0]   rr4  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [3:0]   rdy13[4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
    logic [1:0]   sel3 [4] = '{2'd0, 2'd2, 2'd0, 2'd2};

    arbiter_multiplexer #(.WIDTH(W), .CHANNELS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_bus    (in_bus),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    arbiter_multiplexer #(.WIDTH(W), .CHANNELS(3)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .in_bus    (in_bus3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_sel   (out_sel3),
        .out_valid (out_valid3),
        .out_ready (out_ready3)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] d, input logic [1:0] s);
        beat_t b;
        b.data = d;
        b.sel  = s;
        exp_q.push_back(b);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Scoreboard monitor: every output handshake pops one expected beat.
    always @(negedge clock) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: got data %0h sel %0d with nothing expected",
                         out_data, out_sel);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("beat_data", 64'(out_data), 64'(b.data));
                check("beat_sel", 64'(out_sel), 64'(b.sel));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        in_bus    = '0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_bus3   = '0;
        in_valid3 = '0;
        out_ready3 = 1'b1;
        step(2);
        reset = 1'b0;

        // Reset state
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_sel", 64'(out_sel), 64'd0);
        check("rst_ready_idle", 64'(in_ready), 64'd0);
        in_valid = 4'b1111;
        #1;
        check("rst_grant", 64'(in_ready), 64'b0001);
        in_valid = 4'b0000;

        // Single channel 2 streaming
        in_bus    = {D0, D1, 32'hDEADBEEF, D3};
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        repeat (4) push(32'hDEADBEEF, 2'd2);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("single_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 4'b0000;
        step(2);

        // Async reset discards a held beat before the next edge
        out_ready = 1'b0;
        in_valid  = 4'b0100;
        step(1);
        in_valid = 4'b0000;
        check("held_valid", 64'(out_valid), 64'd1);
        check("held_data", 64'(out_data), 64'hDEADBEEF);
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_data", 64'(out_data), 64'd0);
        check("async_rst_sel", 64'(out_sel), 64'd0);
        step(1);
        reset = 1'b0;

        // Round robin, all channels valid; first grant proves ptr reset to 0
        in_bus    = {D0, D1, D2, D3};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        check("ptr_after_rst", 64'(in_ready), 64'b0001);
        for (int i = 0; i < 6; i++) begin
            push(dch[RR ? rr4[i] : 2'd0], RR ? rr4[i] : 2'd0);
        end
        step(6);
        in_valid = 4'b0000;
        step(2);

        // Backpressure then drain-and-reload without a bubble
        reset = 1'b1;
        step(1);
        reset     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        step(1);
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 64'(in_ready), 64'd0);
            check("bp_data", 64'(out_data), 64'(D0));
            check("bp_sel", 64'(out_sel), 64'd0);
            check("bp_valid", 64'(out_valid), 64'd1);
            step(1);
        end
        push(D0, 2'd0);
        push(RR ? D1 : D0, RR ? 2'd1 : 2'd0);
        push(RR ? D2 : D0, RR ? 2'd2 : 2'd0);
        out_ready = 1'b1;
        step(1);
        check("reload_valid", 64'(out_valid), 64'd1);
        check("reload_sel", 64'(out_sel), RR ? 64'd1 : 64'd0);
        step(1);
        in_valid = 4'b0000;
        step(2);

        // Channels 1 and 3 competing
        reset = 1'b1;
        step(1);
        reset    = 1'b0;
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            push(RR ? dch[(i % 2) ? 3 : 1] : D1, RR ? ((i % 2) ? 2'd3 : 2'd1) : 2'd1);
        end
        #1;
        for (int i = 0; i < 4; i++) begin
            check("pair_ready", 64'(in_ready), RR ? 64'(rdy13[i]) : 64'b0010);
            step(1);
        end
        in_valid = 4'b0000;
        step(2);

        // Three-channel wrap, channels 0 and 2 valid
        reset = 1'b1;
        step(1);
        reset     = 1'b0;
        in_bus3   = {E0, E1, E2};
        in_valid3 = 3'b101;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check("wrap_valid", 64'(out_valid3), 64'd1);
            check("wrap_sel", 64'(out_sel3), RR ? 64'(sel3[i]) : 64'd0);
            check("wrap_data", 64'(out_data3), RR ? 64'(ech[sel3[i]]) : 64'(E0));
        end
        in_valid3 = 3'b000;
        step(3);

        check("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
